// File: rtl/mult_accumulate_stage.sv
`default_nettype none
// ============================================================================
// Module      : mult_accumulate_stage
// Description : Signed product accumulator with a valid/ready input, per-beat
//               ADD/SUB/LOAD/NOP operations and a one-deep result register.
//               Optional feature macro: MAC_SATURATE_EN clamps the accumulator
//               on overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_accumulate_stage #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_prod,
  input  logic [1:0]           in_op,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam logic [1:0] c_op_add  = 2'b00;
  localparam logic [1:0] c_op_sub  = 2'b01;
  localparam logic [1:0] c_op_load = 2'b10;
  localparam int         c_msb     = ACC_WIDTH - 1;

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic [ACC_WIDTH-1:0]   r_out_acc;
  logic [CNT_WIDTH-1:0]   r_out_cnt;
  logic                   r_out_ovf;

  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic [ACC_WIDTH-1:0]   w_s;
  logic [ACC_WIDTH-1:0]   w_base;
  logic [CNT_WIDTH-1:0]   w_cnt_base;
  logic                   w_ovf_base;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic [ACC_WIDTH-1:0]   w_diff;
  logic [ACC_WIDTH-1:0]   w_raw;
  logic [ACC_WIDTH-1:0]   w_acc_next;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_ovf_hit;
  logic                   w_ovf_next;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_s        = {{(ACC_WIDTH-WIDTH){in_prod[WIDTH-1]}}, in_prod};

  // A sequence always starts from a clean slate, whatever the registers hold.
  assign w_base     = (r_state == ST_RUN) ? r_acc : '0;
  assign w_cnt_base = (r_state == ST_RUN) ? r_cnt : '0;
  assign w_ovf_base = (r_state == ST_RUN) ? r_ovf : 1'b0;

  always_comb begin
    w_state_next = r_state;
    if (w_in_xfer) begin
      w_state_next = in_last ? ST_IDLE : ST_RUN;
    end
  end

  always_comb begin
    w_sum      = w_base + w_s;
    w_diff     = w_base - w_s;
    w_raw      = w_base;
    w_ovf_hit  = 1'b0;
    w_acc_next = w_base;
    case (in_op)
      c_op_add: begin
        w_raw     = w_sum;
        w_ovf_hit = (w_base[c_msb] == w_s[c_msb]) && (w_sum[c_msb] != w_base[c_msb]);
      end
      c_op_sub: begin
        w_raw     = w_diff;
        w_ovf_hit = (w_base[c_msb] != w_s[c_msb]) && (w_diff[c_msb] != w_base[c_msb]);
      end
      c_op_load: w_raw = w_s;
      default:   w_raw = w_base;
    endcase
`ifdef MAC_SATURATE_EN
    // Overflow direction always follows the sign of the old accumulator.
    if (w_ovf_hit) begin
      w_acc_next = w_base[c_msb] ? c_acc_min : c_acc_max;
    end else begin
      w_acc_next = w_raw;
    end
`else
    w_acc_next = w_raw;
`endif
  end

  assign w_ovf_next = w_ovf_base | w_ovf_hit;
  assign w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_in_xfer) begin
      if (in_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        r_ovf <= w_ovf_next;
      end
    end
  end

  // A new result takes priority over the consumer draining the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_in_xfer && in_last) begin
      r_out_valid <= 1'b1;
      r_out_acc   <= w_acc_next;
      r_out_cnt   <= w_cnt_next;
      r_out_ovf   <= w_ovf_next;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulate_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_accumulate_stage
// Description : Directed self-checking bench; three instances cover the
//               default, 33-bit accumulator and 4-bit counter configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_accumulate_stage;

  localparam logic [1:0] c_add  = 2'b00;
  localparam logic [1:0] c_sub  = 2'b01;
  localparam logic [1:0] c_load = 2'b10;
  localparam logic [1:0] c_nop  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_prod = '0;
  logic [1:0]  in_op = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [47:0] a_out_acc;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [32:0] b_out_acc;
  logic [7:0]  b_out_count;
  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [47:0] c_out_acc;
  logic [3:0]  c_out_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_accumulate_stage #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .in_op(in_op), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
    .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  mult_accumulate_stage #(.WIDTH(32), .ACC_WIDTH(33), .CNT_WIDTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .in_op(in_op), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
    .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  mult_accumulate_stage #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_prod(in_prod), .in_op(in_op), .in_last(in_last),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_acc(c_out_acc),
    .out_count(c_out_count), .out_ovf(c_out_ovf)
  );

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [1:0] op, input logic [31:0] p, input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_prod  = p;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready} !== {1'b0, 48'd0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a: got v=%0b acc=%0h cnt=%0d ovf=%0b rdy=%0b, expected 0/0/0/0/1",
               a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready);
    end
    n_tests++;
    if ({b_out_valid, b_out_acc, c_out_valid, c_out_count, b_in_ready, c_in_ready} !== {1'b0, 33'd0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_bc: got bv=%0b bacc=%0h cv=%0b ccnt=%0d, expected zeros with ready",
               b_out_valid, b_out_acc, c_out_valid, c_out_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add;
    out_ready = 1'b1;
    send(c_add, 32'd3, 1'b0);
    send(c_add, 32'd5, 1'b0);
    send(c_add, 32'hFFFF_FFFF, 1'b1);
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf} !== {1'b1, 48'd7, 8'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_add: got v=%0b acc=%0h cnt=%0d ovf=%0b, expected 1/7/3/0",
               a_out_valid, a_out_acc, a_out_count, a_out_ovf);
    end
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consume: got out_valid=%0b, expected 0", a_out_valid);
    end
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    send(c_load, 32'd100, 1'b0);
    send(c_sub, 32'd40, 1'b0);
    send(c_nop, 32'd12345, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready} !== {1'b1, 48'd60, 8'd3, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: got v=%0b acc=%0h cnt=%0d ovf=%0b rdy=%0b, expected 1/3c/3/0/0",
                 i, a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready_comb: got in_ready=%0b, expected 1", a_in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got out_valid=%0b, expected 0", a_out_valid);
    end
  endtask

  task automatic test_overflow;
    logic [32:0] exp_pos;
    logic [32:0] exp_neg;
`ifdef MAC_SATURATE_EN
    exp_pos = 33'h0_FFFF_FFFF;
    exp_neg = 33'h1_0000_0000;
`else
    exp_pos = 33'h1_0000_0000;
    exp_neg = 33'h0_FFFF_FFFF;
`endif
    out_ready = 1'b1;
    send(c_add, 32'h7FFF_FFFF, 1'b0);
    send(c_add, 32'h7FFF_FFFF, 1'b0);
    send(c_add, 32'h0000_0002, 1'b1);
    n_tests++;
    if ({b_out_valid, b_out_acc, b_out_count, b_out_ovf} !== {1'b1, exp_pos, 8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_pos: got v=%0b acc=%0h cnt=%0d ovf=%0b, expected 1/%0h/3/1",
               b_out_valid, b_out_acc, b_out_count, b_out_ovf, exp_pos);
    end
    n_tests++;
    if ({a_out_acc, a_out_ovf} !== {48'h0001_0000_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_pos_wide: got acc=%0h ovf=%0b, expected 100000000/0", a_out_acc, a_out_ovf);
    end
    send(c_load, 32'h8000_0000, 1'b0);
    send(c_add, 32'h8000_0000, 1'b0);
    send(c_sub, 32'h0000_0001, 1'b0);
    send(c_nop, 32'h0000_0000, 1'b1);
    n_tests++;
    if ({b_out_valid, b_out_acc, b_out_count, b_out_ovf} !== {1'b1, exp_neg, 8'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_neg_sticky: got v=%0b acc=%0h cnt=%0d ovf=%0b, expected 1/%0h/4/1",
               b_out_valid, b_out_acc, b_out_count, b_out_ovf, exp_neg);
    end
    n_tests++;
    if ({a_out_acc, a_out_count, a_out_ovf} !== {48'hFFFE_FFFF_FFFF, 8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_neg_wide: got acc=%0h cnt=%0d ovf=%0b, expected fffeffffffff/4/0",
               a_out_acc, a_out_count, a_out_ovf);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_op    = c_add;
      in_prod  = 32'(k);
      in_last  = 1'b1;
      #1;
      n_tests++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: got in_ready=%0b, expected 1", k, a_in_ready);
      end
      @(negedge clk);
      n_tests++;
      if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf} !== {1'b1, 48'(k), 8'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: got v=%0b acc=%0h cnt=%0d ovf=%0b, expected 1/%0h/1/0",
                 k, a_out_valid, a_out_acc, a_out_count, a_out_ovf, k);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_count_saturate;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(c_add, 32'd1, 1'b0);
    end
    send(c_add, 32'd1, 1'b1);
    n_tests++;
    if ({c_out_valid, c_out_acc, c_out_count, c_out_ovf} !== {1'b1, 48'd21, 4'd15, 1'b0}) begin
      n_fail++;
      $display("FAIL cnt_sat: got v=%0b acc=%0h cnt=%0d ovf=%0b, expected 1/15/15/0",
               c_out_valid, c_out_acc, c_out_count, c_out_ovf);
    end
    n_tests++;
    if ({a_out_acc, a_out_count} !== {48'd21, 8'd21}) begin
      n_fail++;
      $display("FAIL cnt_wide: got acc=%0h cnt=%0d, expected 15/21", a_out_acc, a_out_count);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    @(negedge clk);
    send(c_add, 32'd5, 1'b0);
    send(c_add, 32'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready} !== {1'b0, 48'd0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_seq: got v=%0b acc=%0h cnt=%0d ovf=%0b rdy=%0b, expected 0/0/0/0/1",
               a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(c_add, 32'd9, 1'b1);
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf} !== {1'b1, 48'd9, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_after_seq: got v=%0b acc=%0h cnt=%0d ovf=%0b, expected 1/9/1/0",
               a_out_valid, a_out_acc, a_out_count, a_out_ovf);
    end
    @(negedge clk);
    out_ready = 1'b0;
    send(c_add, 32'd7, 1'b1);
    @(negedge clk);
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count} !== {1'b1, 48'd7, 8'd1}) begin
      n_fail++;
      $display("FAIL rst_held_pre: got v=%0b acc=%0h cnt=%0d, expected 1/7/1",
               a_out_valid, a_out_acc, a_out_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready} !== {1'b0, 48'd0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_held: got v=%0b acc=%0h cnt=%0d ovf=%0b rdy=%0b, expected 0/0/0/0/1",
               a_out_valid, a_out_acc, a_out_count, a_out_ovf, a_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(c_add, 32'd9, 1'b1);
    n_tests++;
    if ({a_out_valid, a_out_acc, a_out_count} !== {1'b1, 48'd9, 8'd1}) begin
      n_fail++;
      $display("FAIL rst_held_after: got v=%0b acc=%0h cnt=%0d, expected 1/9/1",
               a_out_valid, a_out_acc, a_out_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_count_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_accumulate_stage.md
# mult_accumulate_stage

Downstream consumer of the 32-bit multiplier's `prod` output. Accepts a stream of products over a valid/ready handshake and accumulates them as signed values into a wide accumulator. Each product beat carries an operation: add, subtract, load or no-op. A beat flagged `in_last` closes the sequence and hands the result, with beat count and overflow status, to a one-deep output register for the consumer.

## Interface
Parameters
- `WIDTH`, 32: product width; matches the multiplier's `WIDTH`.
- `ACC_WIDTH`, 48: accumulator width; must be greater than `WIDTH`.
- `CNT_WIDTH`, 8: beat-counter width.

Ports
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: the product beat is valid.
- `in_ready`, output, 1: the stage can accept a beat.
- `in_prod`, input, `WIDTH`: product, treated as two's-complement.
- `in_op`, input, 2: 00 ADD, 01 SUB, 10 LOAD, 11 NOP.
- `in_last`, input, 1: final beat of the sequence.
- `out_valid`, output, 1: result register holds an unconsumed result.
- `out_ready`, input, 1: consumer accepts the result.
- `out_acc`, output, `ACC_WIDTH`: accumulated result.
- `out_count`, output, `CNT_WIDTH`: number of beats in the sequence, including the last.
- `out_ovf`, output, 1: an overflow occurred somewhere in the sequence.

## Operation
- Input transfer: `in_valid && in_ready` on a rising edge.
- Output transfer: `out_valid && out_ready` on a rising edge.
- `in_ready` is combinational: `!out_valid || out_ready`. It stalls only while an unconsumed result is blocking the output register.
- State machine states:
  - IDLE: no beats accepted since reset or since the last `in_last`. The accumulator, count and overflow flag are all 0.
  - RUN: at least one beat of the current sequence has been accepted.
- State transitions:
  - IDLE to RUN: transfer with `in_last`=0.
  - RUN to IDLE: transfer with `in_last`=1.
  - IDLE to IDLE: transfer with `in_last`=1 (a single-beat sequence).
- Per-beat update. `s` is `in_prod` sign-extended to `ACC_WIDTH`.
  - ADD: `acc + s`.
  - SUB: `acc - s`.
  - LOAD: `s`.
  - NOP: `acc` unchanged.
- Overflow:
  - Signed overflow of the ADD or SUB result at `ACC_WIDTH` bits sets the sticky per-sequence overflow flag.
  - LOAD and NOP never overflow.
- Beat counter: increments on each transfer and saturates at all-ones.
- Last beat:
  - The updated accumulator, updated count and updated overflow flag go into the output register, and `out_valid` is set.
  - The internal accumulator, counter and flag clear to 0 on the same edge.
- Simultaneous events: an output transfer and a last-beat input transfer on the same edge load the new result, and `out_valid` stays 1.
- Output hold: output register contents stay stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-sequence: the partial accumulation, count and any held result are discarded.

## Timing
- Reset values:
  - `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0.
  - Internal accumulator, counter and flag are 0; state is IDLE.
  - `in_ready`=1.
- Latency: the result is visible with `out_valid`=1 in the cycle after the last-beat transfer edge.
- Throughput: one beat per cycle, including back-to-back single-beat sequences, while `out_ready`=1.
- `in_ready` has a combinational dependency on `out_ready` only; there is no path from `in_valid` to `in_ready`.

## Configuration
- `MAC_SATURATE_EN` defined:
  - On ADD or SUB overflow, the accumulator clamps to 2^(ACC_WIDTH-1)-1 when positive overflow occurs.
  - It clamps to -2^(ACC_WIDTH-1) when negative overflow occurs.
  - The overflow flag is set.
- `MAC_SATURATE_EN` undefined:
  - The accumulator wraps modulo 2^ACC_WIDTH.
  - The overflow flag is still set.

## Test plan
- Reset release, then ADD 3, ADD 5, ADD 0xFFFFFFFF (last) -> one cycle later `out_valid`=1, `out_acc`=7, `out_count`=3, `out_ovf`=0.
- LOAD 100, SUB 40, NOP (last) with `out_ready`=0 for 5 cycles -> `out_acc`=60, `out_count`=3, held stable; `in_ready`=0 during the hold; the result clears after `out_ready`=1.
- `ACC_WIDTH`=33: ADD 0x7FFFFFFF, ADD 0x7FFFFFFF, ADD 0x00000002 (last) -> `out_ovf`=1.
  - With the macro, `out_acc`=0x0FFFFFFFF.
  - Without the macro, `out_acc`=0x100000000.
- Single-beat sequences (ADD k, last) for k=1..4 with `out_ready`=1 -> four results 1, 2, 3, 4 on consecutive cycles, each `out_count`=1, `in_ready` never low.
- `CNT_WIDTH`=4: 20 ADD 1 beats, then the last -> `out_count`=15, `out_acc`=21.
- Assert `rst_n`=0 asynchronously mid-sequence and while a result is held -> all outputs 0 immediately; the next sequence ADD 9 (last) gives `out_acc`=9, `out_count`=1.
